multicycle_controller: RTL

- Control unit for the multicycle RV32I core, the successor to the single-cycle controller.
- Moore FSM sequences fetch/decode/execute/memory/writeback over 3–5 cycles per instruction and shares one ALU and one memory port.
- Adds full branch set (beq/bne/blt/bge/bltu/bgeu), jalr, lui, auipc, an illegal-instruction flag and an optional memory wait-state handshake.
- Sits between the instruction register and the multicycle datapath muxes and enables.

---
 rtl/multicycle_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_controller : Moore FSM control unit for the multicycle RV32I core.
// Optional memory wait-state handshake enabled by defining MEM_WAIT_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int ALUCTRL_W = 4,
  parameter int IMMSRC_W  = 3,
  parameter int STATE_W   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
`ifdef MEM_WAIT_EN
  input  logic                 mem_ready_i,
`endif
  input  logic [6:0]           op_i,
  input  logic [2:0]           funct3_i,
  input  logic                 funct7b5_i,
  input  logic                 zero_i,
  input  logic                 negative_i,
  input  logic                 overflow_i,
  input  logic                 carry_i,
  output logic                 pcwrite_o,
  output logic                 adrsrc_o,
  output logic                 memwrite_o,
  output logic                 irwrite_o,
  output logic [1:0]           resultsrc_o,
  output logic [1:0]           alusrca_o,
  output logic [1:0]           alusrcb_o,
  output logic [ALUCTRL_W-1:0] alucontrol_o,
  output logic [IMMSRC_W-1:0]  immsrc_o,
  output logic                 regwrite_o,
  output logic                 illegal_o,
  output logic                 instrdone_o,
  output logic [STATE_W-1:0]   state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
    S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR = 4'd6,  S_EXECI   = 4'd7,
    S_ALUWB    = 4'd8,  S_BRANCH = 4'd9,  S_JALR   = 4'd10, S_JAL     = 4'd11,
    S_LUI      = 4'd12, S_AUIPC  = 4'd13, S_ILLEGAL = 4'd14
  } state_e;

  typedef struct packed {
    logic                 pcwrite;
    logic                 adrsrc;
    logic                 memwrite;
    logic                 irwrite;
    logic [1:0]           resultsrc;
    logic [1:0]           srca;
    logic [1:0]           srcb;
    logic [ALUCTRL_W-1:0] alu;
    logic [IMMSRC_W-1:0]  imm;
    logic                 regwrite;
    logic                 illegal;
    logic                 done;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   mem_ready;
  logic   taken;

`ifdef MEM_WAIT_EN
  assign mem_ready = mem_ready_i;
`else
  assign mem_ready = 1'b1;
`endif

  function automatic logic [ALUCTRL_W-1:0] alu_decode(input logic [6:0] op,
                                                       input logic [2:0] f3,
                                                       input logic f7b5);
    logic [3:0] a;
    case (f3)
      3'b000:  a = (op == 7'b0110011 && f7b5) ? 4'd1 : 4'd0;
      3'b001:  a = 4'd7;
      3'b010:  a = 4'd5;
      3'b011:  a = 4'd6;
      3'b100:  a = 4'd4;
      3'b101:  a = f7b5 ? 4'd9 : 4'd8;
      3'b110:  a = 4'd3;
      default: a = 4'd2;
    endcase
    return ALUCTRL_W'(a);
  endfunction

  // Control word for a state; registered on entry so outputs are glitch-free.
  function automatic ctrl_t ctrl_for(input state_e s, input logic [6:0] op,
                                     input logic [2:0] f3, input logic f7b5);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.srcb = 2'b10; c.resultsrc = 2'b10; end
      S_DECODE:   begin c.srca = 2'b01; c.srcb = 2'b01; c.imm = IMMSRC_W'(3'd2); end
      S_MEMADR:   begin c.srca = 2'b10; c.srcb = 2'b01; c.imm = IMMSRC_W'({2'b00, op[5]}); end
      S_MEMREAD:  c.adrsrc = 1'b1;
      S_MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; c.done = 1'b1; end
      S_MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; c.done = 1'b1; end
      S_EXECR:    begin c.srca = 2'b10; c.alu = alu_decode(op, f3, f7b5); end
      S_EXECI:    begin c.srca = 2'b10; c.srcb = 2'b01; c.alu = alu_decode(op, f3, f7b5); end
      S_ALUWB:    begin c.regwrite = 1'b1; c.done = 1'b1; end
      S_BRANCH:   begin c.srca = 2'b10; c.alu = ALUCTRL_W'(4'd1); c.done = 1'b1;
                        c.illegal = (f3[2:1] == 2'b01); end
      S_JALR:     begin c.srca = 2'b10; c.srcb = 2'b01; end
      S_JAL:      begin c.srca = 2'b01; c.srcb = 2'b10; c.pcwrite = 1'b1; end
      S_LUI:      begin c.srca = 2'b11; c.srcb = 2'b01; c.imm = IMMSRC_W'(3'd4); end
      S_AUIPC:    begin c.srca = 2'b01; c.srcb = 2'b01; c.imm = IMMSRC_W'(3'd4); end
      default:    begin c.illegal = 1'b1; c.done = 1'b1; end
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALR;
          7'b0110111:             state_d = S_LUI;
          7'b0010111:             state_d = S_AUIPC;
          default:                state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_LUI, S_AUIPC: state_d = S_ALUWB;
      S_JALR:     state_d = S_JAL;
      default:    state_d = S_FETCH;
    endcase
  end

  assign ctrl_d = ctrl_for(state_d, op_i, funct3_i, funct7b5_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_for(S_FETCH, 7'd0, 3'd0, 1'b0);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (funct3_i)
      3'b000:  taken = zero_i;
      3'b001:  taken = !zero_i;
      3'b100:  taken = negative_i ^ overflow_i;
      3'b101:  taken = !(negative_i ^ overflow_i);
      3'b110:  taken = !carry_i;
      3'b111:  taken = carry_i;
      default: taken = 1'b0;
    endcase
  end

  // Write enables are gated by reset so an in-flight instruction writes nothing.
  assign pcwrite_o    = rst_ni & ((state_q == S_BRANCH) ? taken
                                  : (ctrl_q.pcwrite & (mem_ready | (state_q != S_FETCH))));
  assign irwrite_o    = rst_ni & ctrl_q.irwrite & mem_ready;
  assign memwrite_o   = rst_ni & ctrl_q.memwrite;
  assign regwrite_o   = rst_ni & ctrl_q.regwrite;
  assign illegal_o    = rst_ni & ctrl_q.illegal;
  assign instrdone_o  = rst_ni & ctrl_q.done & (mem_ready | (state_q != S_MEMWRITE));
  assign adrsrc_o     = ctrl_q.adrsrc;
  assign resultsrc_o  = ctrl_q.resultsrc;
  assign alusrca_o    = ctrl_q.srca;
  assign alusrcb_o    = ctrl_q.srcb;
  assign alucontrol_o = ctrl_q.alu;
  assign immsrc_o     = ctrl_q.imm;
  assign state_o      = STATE_W'(state_q);

endmodule
`default_nettype wire
